video_capture: RTL and testbench

Pixel-stream capture stage between the arcade core's raw video outputs and the simulation display sink. It samples the 9-bit RGB and sync/blank signals at pixel rate and tracks the beam position (x, y). Visible pixels are packed to ARGB8888 and delivered through a small FIFO with a valid/ready handshake. The sink can therefore stall without the core's timing changing, and any pixel loss is reported explicitly.

---
 rtl/video_capture_pkg.sv | 32 +++
 rtl/video_capture_fifo.sv | 55 +++++
 rtl/video_capture.sv | 171 +++++++++++++++++
 tb/tb_video_capture.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_capture_pkg.sv
// rtl/video_capture_pkg.sv - shared types and helpers for the video capture stage
//   px_entry_t : one queued pixel {data, x, y, sof, eol}
//   state_t    : beam-tracking FSM states
//   pack_argb  : 9-bit RGB333 to ARGB8888
//   sat_inc    : 9-bit coordinate increment that saturates at 511
package video_capture_pkg;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        FRAME     = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eol;
    } px_entry_t;

    localparam logic [8:0] COORD_MAX = 9'h1FF;

    // Each 3-bit channel lands in the top bits of its byte; alpha is opaque.
    function automatic logic [31:0] pack_argb(input logic [8:0] rgb);
        return {8'hFF, rgb[2:0], 5'b0, rgb[5:3], 5'b0, rgb[8:6], 5'b0};
    endfunction

    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == COORD_MAX) ? v : v + 9'd1;
    endfunction

endpackage

// File: rtl/video_capture_fifo.sv
// rtl/video_capture_fifo.sv - synchronous first-word-fall-through FIFO
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data  : write request; accepted when not full or when a read happens in the same cycle
//   rd_en, rd_data  : read request (ignored when empty); rd_data always shows the head entry
//   full, empty     : occupancy flags
module video_capture_fifo #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/video_capture.sv
// rtl/video_capture.sv - raw video sampling, beam tracking and pixel FIFO output
//   clk, reset_n                      : clock, asynchronous active-low reset
//   rgb_i, hsync_i, vsync_i           : raw colour and active-low syncs from the core
//   hblank_i, vblank_i                : active-high blanking
//   px_valid, px_ready                : output handshake, pop on valid && ready
//   px_data, px_x, px_y, px_sof, px_eol : FIFO head (zero while empty)
//   frame_done, frame_count           : per-frame pulse and wrapping frame counter
//   overflow, ovf_clr_i               : sticky pixel-drop flag and its clear
module video_capture
    import video_capture_pkg::*;
#(
    parameter int H_ACTIVE   = 256,
    parameter int V_ACTIVE   = 240,
    parameter int PIX_DIV    = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  rgb_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        hblank_i,
    input  logic        vblank_i,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [31:0] px_data,
    output logic [8:0]  px_x,
    output logic [8:0]  px_y,
    output logic        px_sof,
    output logic        px_eol,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        overflow,
    input  logic        ovf_clr_i
);

    localparam int                DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]        H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);

    logic [8:0]       rgb_q;
    logic             hsync_q, vsync_q, hblank_q, vblank_q;
    logic             hsync_prev_q, vsync_prev_q, hblank_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    state_t           state_q, state_d;
    logic [8:0]       x_q, x_d, y_q, y_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             overflow_q, overflow_d;

    logic             ce, vs_fall, hb_rise, active, in_window, push, pop;
    logic             fifo_full, fifo_empty;
    px_entry_t        entry_in, head;
    logic             sync_unused;

    // hsync is kept with its history for completeness, but lines are
    // delimited by hblank so nothing downstream consumes it.
    assign sync_unused = hsync_q ^ hsync_prev_q;

    assign ce        = (div_q == DIV_LAST);
    assign vs_fall   = vsync_prev_q && !vsync_q;
    assign hb_rise   = hblank_q && !hblank_prev_q;
    assign active    = ce && !hblank_q && !vblank_q;
    assign in_window = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
    assign pop       = !fifo_empty && px_ready;

    assign entry_in.data = pack_argb(rgb_q);
    assign entry_in.x    = x_q;
    assign entry_in.y    = y_q;
    assign entry_in.sof  = (x_q == 9'd0) && (y_q == 9'd0);
    assign entry_in.eol  = ({1'b0, x_q} == H_LIM - 10'd1);

    always_comb begin
        div_d         = ce ? '0 : div_q + DIV_W'(1);
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_count_d = frame_count_q;
        frame_done    = 1'b0;
        push          = 1'b0;
        case (state_q)
            SYNC_WAIT: begin
                if (vs_fall) begin
                    state_d = FRAME;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            FRAME: begin
                if (vs_fall) begin
                    frame_done    = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    x_d           = '0;
                    y_d           = '0;
                end else if (hb_rise && (x_q != 9'd0)) begin
                    x_d = '0;
                    y_d = sat_inc(y_q);
                end else if (active) begin
                    // Clipped pixels still advance x so later lines stay aligned.
                    push = in_window;
                    x_d  = sat_inc(x_q);
                end
            end
            default: state_d = SYNC_WAIT;
        endcase
        // A simultaneous pop frees the slot, so only a push into a full FIFO
        // without a pop loses the pixel. A drop beats a clear in the same cycle.
        if (push && fifo_full && !pop) overflow_d = 1'b1;
        else if (ovf_clr_i)            overflow_d = 1'b0;
        else                           overflow_d = overflow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_prev_q  <= 1'b1;
            vsync_prev_q  <= 1'b1;
            hblank_prev_q <= 1'b0;
            div_q         <= '0;
            state_q       <= SYNC_WAIT;
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            rgb_q         <= rgb_i;
            hsync_q       <= hsync_i;
            vsync_q       <= vsync_i;
            hblank_q      <= hblank_i;
            vblank_q      <= vblank_i;
            hsync_prev_q  <= hsync_q;
            vsync_prev_q  <= vsync_q;
            hblank_prev_q <= hblank_q;
            div_q         <= div_d;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
        end
    end

    video_capture_fifo #(
        .WIDTH ($bits(px_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (push),
        .wr_data (entry_in),
        .rd_en   (px_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The FIFO memory is not reset, so outputs are forced to zero while empty.
    assign px_valid    = !fifo_empty;
    assign px_data     = fifo_empty ? '0 : head.data;
    assign px_x        = fifo_empty ? '0 : head.x;
    assign px_y        = fifo_empty ? '0 : head.y;
    assign px_sof      = !fifo_empty && head.sof;
    assign px_eol      = !fifo_empty && head.eol;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_video_capture.sv
// tb/tb_video_capture.sv - self-checking bench for video_capture
module tb_video_capture;

    localparam int H = 4;
    localparam int V = 2;
    localparam int DIV = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  rgb_i = '0;
    logic        hsync_i = 1'b1, vsync_i = 1'b1, hblank_i = 1'b1, vblank_i = 1'b1;
    logic        px_ready = 1'b0, ovf_clr_i = 1'b0;
    logic        px_valid, px_sof, px_eol, frame_done, overflow;
    logic [31:0] px_data;
    logic [8:0]  px_x, px_y;
    logic [15:0] frame_count;

    video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .rgb_i(rgb_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .hblank_i(hblank_i), .vblank_i(vblank_i), .px_valid(px_valid), .px_ready(px_ready),
        .px_data(px_data), .px_x(px_x), .px_y(px_y), .px_sof(px_sof), .px_eol(px_eol),
        .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0, fails = 0;
    int cyc = 0;
    int valid_cycles = 0, fd_high = 0, fd_pulses = 0;
    logic fd_prev = 1'b0;
    logic [51:0] got[$];
    logic [51:0] exp_q[$];
    bit stalled = 0;
    bit exp_ovf = 0;

    // Posedges since reset release: the free-running divider fires ce in the
    // cycle following every odd-numbered edge.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clk) begin
        if (px_valid && px_ready) got.push_back({px_data, px_x, px_y, px_sof, px_eol});
        if (px_valid) valid_cycles <= valid_cycles + 1;
        if (frame_done) fd_high <= fd_high + 1;
        if (frame_done && !fd_prev) fd_pulses <= fd_pulses + 1;
        fd_prev <= frame_done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        int guard = 0;
        while (cyc[0] && guard < 4) begin
            tick(1);
            guard++;
        end
    endtask

    function automatic logic [51:0] model_px(input logic [8:0] c, input int x, input int y);
        int r = int'(c) % 8;
        int g = (int'(c) / 8) % 8;
        int b = int'(c) / 64;
        logic [31:0] d = 32'hFF000000 + 32'(r * 2097152) + 32'(g * 8192) + 32'(b * 32);
        logic sof = (x == 0 && y == 0);
        logic eol = (x == H - 1);
        return {d, 9'(x), 9'(y), sof, eol};
    endfunction

    task automatic pix(input logic [8:0] c, input int x, input int y);
        rgb_i = c; hblank_i = 0; vblank_i = 0;
        tick(DIV);
        if (x < H && y < V) begin
            if (stalled && exp_q.size() >= DEPTH) exp_ovf = 1;
            else exp_q.push_back(model_px(c, x, y));
        end
    endtask

    task automatic line(input int len, input int y, input bit rnd, input logic [8:0] fixed);
        for (int x = 0; x < len; x++) pix(rnd ? 9'($urandom) : fixed, x, y);
        hblank_i = 1;
        tick(DIV);
    endtask

    task automatic vsync_pulse();
        align();
        vblank_i = 1; hblank_i = 1; vsync_i = 0;
        tick(DIV);
        vsync_i = 1;
        tick(DIV);
    endtask

    task automatic frame(input int nl, input int len);
        vsync_pulse();
        for (int y = 0; y < nl; y++) line(len, y, 1'b1, 9'h0);
        vblank_i = 1;
        tick(DIV);
    endtask

    task automatic compare_pops(input string tag, input int mark);
        int n = got.size() - mark;
        check($sformatf("%s_count", tag), 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s_px%0d", tag, i), 64'(got[mark + i]), 64'(exp_q[i]));
    endtask

    initial begin
        int mark, vc, nl, len;
        logic [8:0] c;

        // Reset state
        tick(2);
        check("rst_valid", 64'(px_valid), 64'd0);
        check("rst_data", 64'(px_data), 64'd0);
        check("rst_xy", 64'({px_x, px_y, px_sof, px_eol}), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset_n = 1;
        px_ready = 1;

        // Active pixels without any vsync: nothing captured
        vc = valid_cycles;
        align();
        line(6, 0, 1'b1, 9'h0);
        line(6, 1, 1'b1, 9'h0);
        exp_q.delete();
        tick(4);
        check("nosync_valid", 64'(valid_cycles - vc), 64'd0);
        check("nosync_frame_count", 64'(frame_count), 64'd0);

        // Small frame with a blank-only hblank pulse (x==0) before the lines
        mark = got.size();
        vsync_pulse();
        hblank_i = 0; tick(DIV);
        hblank_i = 1; tick(DIV);
        rgb_i = 9'h1C7; hblank_i = 0; vblank_i = 0;
        tick(1);
        check("lat_1clk_valid", 64'(px_valid), 64'd0);
        tick(1);
        check("lat_2clk_valid", 64'(px_valid), 64'd1);
        check("lat_2clk_data", 64'(px_data), 64'hFFE000E0);
        check("lat_2clk_sof", 64'({px_sof, px_x, px_y}), 64'({1'b1, 9'd0, 9'd0}));
        exp_q.push_back(model_px(9'h1C7, 0, 0));
        for (int x = 1; x < H; x++) pix(9'h1C7, x, 0);
        hblank_i = 1; tick(DIV);
        line(H, 1, 1'b0, 9'h1C7);
        vblank_i = 1; tick(6);
        compare_pops("small", mark);
        check("small_no_fd", 64'(fd_pulses), 64'd0);

        // Randomised frames with clipping in both directions
        for (int f = 0; f < 3; f++) begin
            mark = got.size();
            exp_q.delete();
            nl = $urandom_range(1, 3);
            len = $urandom_range(2, 6);
            frame(nl, len);
            tick(4);
            compare_pops($sformatf("rnd%0d", f), mark);
            check($sformatf("rnd%0d_fd", f), 64'(fd_pulses), 64'(f + 1));
            check($sformatf("rnd%0d_fc", f), 64'(frame_count), 64'(f + 1));
        end

        // Frame counter wrap
        force dut.frame_count_q = 16'hFFFF;
        #2;
        release dut.frame_count_q;
        px_ready = 0;
        stalled = 1;
        exp_q.delete();
        exp_ovf = 0;
        mark = got.size();
        vsync_pulse();
        tick(1);
        check("fc_wrap", 64'(frame_count), 64'd0);

        // Stall: 20 pushes into a 16-deep FIFO
        for (int y = 0; y < V; y++) line(H, y, 1'b1, 9'h0);
        check("stall_head_first", 64'(px_data), 64'(exp_q[0][51:20]));
        frame(V, H);
        frame(1, H);
        tick(2);
        check("stall_overflow", 64'(overflow), 64'(exp_ovf));
        check("stall_head_held", 64'(px_data), 64'(exp_q[0][51:20]));
        px_ready = 1;
        tick(40);
        compare_pops("stall", mark);
        check("ovf_sticky", 64'(overflow), 64'd1);
        ovf_clr_i = 1; tick(1); ovf_clr_i = 0;
        check("ovf_clear", 64'(overflow), 64'd0);

        // Full FIFO with push and pop in the same cycle
        px_ready = 0;
        exp_q.delete();
        mark = got.size();
        frame(V, H);
        frame(V, H);
        vsync_pulse();
        stalled = 0;
        c = 9'($urandom);
        rgb_i = c; hblank_i = 0; vblank_i = 0;
        tick(1);
        px_ready = 1;
        tick(1);
        px_ready = 0;
        exp_q.push_back(model_px(c, 0, 0));
        check("full_pushpop_ovf", 64'(overflow), 64'd0);
        hblank_i = 1; tick(DIV);
        vblank_i = 1; tick(DIV);
        check("full_still_full", 64'(got.size() - mark), 64'd1);
        px_ready = 1;
        tick(40);
        compare_pops("full", mark);
        check("full_ovf_end", 64'(overflow), 64'd0);

        // Reset mid-frame with 5 entries queued
        px_ready = 0;
        stalled = 1;
        exp_q.delete();
        vsync_pulse();
        line(H, 0, 1'b1, 9'h0);
        pix(9'($urandom), 0, 1);
        check("midrst_queued", 64'(exp_q.size()), 64'd5);
        check("midrst_valid_before", 64'(px_valid), 64'd1);
        #2;
        reset_n = 0;
        #1;
        check("midrst_valid_now", 64'(px_valid), 64'd0);
        check("midrst_fc", 64'(frame_count), 64'd0);
        tick(2);
        reset_n = 1;
        stalled = 0;
        px_ready = 1;
        vc = valid_cycles;
        align();
        line(H, 0, 1'b1, 9'h0);
        line(H, 1, 1'b1, 9'h0);
        tick(4);
        check("midrst_ignored", 64'(valid_cycles - vc), 64'd0);
        exp_q.delete();
        mark = got.size();
        frame(1, H);
        tick(4);
        compare_pops("recover", mark);

        check("fd_single_cycle", 64'(fd_high), 64'(fd_pulses));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
